// File: rtl/jitter_clk_pkg.sv
// Shared types and constants for the jittered clock generator.
// Holds the FSM state encoding, LFSR polynomial, default seed and the
// reset values of the active configuration (divide-by-2, no jitter).
package jitter_clk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   // Galois mask for x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_MASK    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // Active config after reset: half = 1, no jitter -> clk_out = clk / 2
   localparam int   RST_HALF   = 1;
   localparam int   RST_JIT    = 0;
   localparam logic RST_JIT_EN = 1'b0;

   // One right-shift step of the Galois LFSR
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) begin
         n = n ^ LFSR_MASK;
      end
      return n;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used as the jitter source.
// The state steps once per cycle while en_i is high and holds otherwise.
module lfsr16
   import jitter_clk_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   output logic [15:0] state_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   // Next value: advance only when enabled
   always_comb begin
      lfsr_d = lfsr_q;
      if (en_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   // State register, reset to the seed
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state_o = lfsr_q;

endmodule

// File: rtl/jitter_clk_gen.sv
// Programmable divided-clock generator with per-half-period LFSR jitter.
// An IDLE/HIGH/LOW FSM times each half with a down-counter loaded from the
// jittered half length; clk_out and the strobes are registered one cycle
// behind the FSM state. A free-running counter measures every period
// between clk_out rising edges.
//
// Config handshake: a transfer happens on a clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is 1 exactly when the single pending slot
// is empty; the offer source must hold cfg_valid and its data stable until
// that edge. The pending config becomes active on the next entry to HIGH,
// and the slot frees (cfg_ready back to 1) at that same edge.
module jitter_clk_gen
   import jitter_clk_pkg::*;
#(
   parameter int          CNT_W = 16,
   parameter int          JIT_W = 8,
   parameter logic [15:0] SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_half,
   input  logic [JIT_W-1:0] cfg_jit,
   input  logic             cfg_jit_en,
   output logic             clk_out,
   output logic             rise_pulse,
   output logic             period_valid,
   output logic [CNT_W:0]   period,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   // Signed width wide enough for half + (r - jit) without overflow
   localparam int AW = ((CNT_W > JIT_W + 1) ? CNT_W : JIT_W + 1) + 2;
   localparam logic signed [AW-1:0] H_ONE = AW'(1);
   localparam logic signed [AW-1:0] H_MAX = $signed(AW'({CNT_W{1'b1}}));

   // FSM and half-period counter
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             promote;

   // Active and pending configuration
   logic [CNT_W-1:0] act_half_q, act_half_d;
   logic [JIT_W-1:0] act_jit_q, act_jit_d;
   logic             act_jit_en_q, act_jit_en_d;
   logic [CNT_W-1:0] pend_half_q, pend_half_d;
   logic [JIT_W-1:0] pend_jit_q, pend_jit_d;
   logic             pend_jit_en_q, pend_jit_en_d;
   logic             pend_valid_q, pend_valid_d;

   // Half-length arithmetic
   logic             use_pend;
   logic [CNT_W-1:0] sel_half;
   logic [JIT_W-1:0] sel_jit;
   logic             sel_jit_en;
   logic [JIT_W:0]   jit2, r_raw, r_clamp;
   logic [CNT_W-1:0] base_half;
   logic signed [AW-1:0] base_s, off_s, h_s;
   logic [CNT_W-1:0] h_sat, h_load;

   // Registered outputs and measurement
   logic             clk_out_q, clk_out_d;
   logic             rise_q, rise_d;
   logic             busy_q, busy_d;
   logic             pv_q, pv_d;
   logic [CNT_W:0]   period_q, period_d;
   logic [CNT_W:0]   meas_cnt_q, meas_cnt_d;
   logic             meas_ok_q, meas_ok_d;

   logic [15:0]      lfsr;
   logic             unused_lfsr;

   lfsr16 #(
      .SEED(SEED)
   ) u_lfsr (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (state_q != IDLE),
      .state_o(lfsr)
   );

   // Only the low JIT_W+1 LFSR bits feed the jitter offset
   assign unused_lfsr = ^lfsr;

   // Pick the config for the half being entered: pending applies only on HIGH entry
   always_comb begin
      use_pend   = pend_valid_q && (state_q != HIGH);
      sel_half   = use_pend ? pend_half_q   : act_half_q;
      sel_jit    = use_pend ? pend_jit_q    : act_jit_q;
      sel_jit_en = use_pend ? pend_jit_en_q : act_jit_en_q;
   end

   // Jittered half length h = half + (clamp(r, 2*jit) - jit), saturated to [1, max]
   always_comb begin
      jit2      = {sel_jit, 1'b0};
      r_raw     = lfsr[JIT_W:0];
      r_clamp   = (r_raw > jit2) ? jit2 : r_raw;
      base_half = (sel_half == '0) ? CNT_W'(1) : sel_half;
      base_s    = $signed(AW'(base_half));
      off_s     = $signed(AW'(r_clamp)) - $signed(AW'(sel_jit));
      h_s       = sel_jit_en ? (base_s + off_s) : base_s;
      if (h_s < H_ONE) begin
         h_sat = CNT_W'(1);
      end else if (h_s > H_MAX) begin
         h_sat = '1;
      end else begin
         h_sat = h_s[CNT_W-1:0];
      end
      h_load = h_sat - CNT_W'(1);
   end

   // FSM next state: each half lasts h cycles; disabling finishes the period first
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      promote = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = HIGH;
               cnt_d   = h_load;
               promote = pend_valid_q;
            end
         end
         HIGH: begin
            if (cnt_q == '0) begin
               state_d = LOW;
               cnt_d   = h_load;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         LOW: begin
            if (cnt_q == '0) begin
               if (enable) begin
                  state_d = HIGH;
                  cnt_d   = h_load;
                  promote = pend_valid_q;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Config slot: accept into pending when empty, promote on HIGH entry
   always_comb begin
      act_half_d    = act_half_q;
      act_jit_d     = act_jit_q;
      act_jit_en_d  = act_jit_en_q;
      pend_half_d   = pend_half_q;
      pend_jit_d    = pend_jit_q;
      pend_jit_en_d = pend_jit_en_q;
      pend_valid_d  = pend_valid_q;
      if (promote) begin
         act_half_d   = pend_half_q;
         act_jit_d    = pend_jit_q;
         act_jit_en_d = pend_jit_en_q;
         pend_valid_d = 1'b0;
      end else if (cfg_valid && cfg_ready) begin
         pend_half_d   = cfg_half;
         pend_jit_d    = cfg_jit;
         pend_jit_en_d = cfg_jit_en;
         pend_valid_d  = 1'b1;
      end
   end

   // Config registers; reset discards any pending offer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_half_q    <= CNT_W'(RST_HALF);
         act_jit_q     <= JIT_W'(RST_JIT);
         act_jit_en_q  <= RST_JIT_EN;
         pend_half_q   <= '0;
         pend_jit_q    <= '0;
         pend_jit_en_q <= 1'b0;
         pend_valid_q  <= 1'b0;
      end else begin
         act_half_q    <= act_half_d;
         act_jit_q     <= act_jit_d;
         act_jit_en_q  <= act_jit_en_d;
         pend_half_q   <= pend_half_d;
         pend_jit_q    <= pend_jit_d;
         pend_jit_en_q <= pend_jit_en_d;
         pend_valid_q  <= pend_valid_d;
      end
   end

   // Output and measurement next values; the counter is invalidated while IDLE
   always_comb begin
      clk_out_d  = (state_q == HIGH);
      busy_d     = (state_q != IDLE);
      rise_d     = (state_q == HIGH) && !clk_out_q;
      pv_d       = 1'b0;
      period_d   = period_q;
      meas_ok_d  = meas_ok_q;
      meas_cnt_d = meas_cnt_q;
      if (rise_d) begin
         meas_cnt_d = '0;
         meas_ok_d  = 1'b1;
         if (meas_ok_q) begin
            pv_d     = 1'b1;
            period_d = (&meas_cnt_q) ? meas_cnt_q : meas_cnt_q + (CNT_W+1)'(1);
         end
      end else begin
         if (!(&meas_cnt_q)) begin
            meas_cnt_d = meas_cnt_q + (CNT_W+1)'(1);
         end
         if (state_q == IDLE) begin
            meas_ok_d = 1'b0;
         end
      end
   end

   // Output and measurement registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_out_q  <= 1'b0;
         rise_q     <= 1'b0;
         busy_q     <= 1'b0;
         pv_q       <= 1'b0;
         period_q   <= '0;
         meas_cnt_q <= '0;
         meas_ok_q  <= 1'b0;
      end else begin
         clk_out_q  <= clk_out_d;
         rise_q     <= rise_d;
         busy_q     <= busy_d;
         pv_q       <= pv_d;
         period_q   <= period_d;
         meas_cnt_q <= meas_cnt_d;
         meas_ok_q  <= meas_ok_d;
      end
   end

   assign cfg_ready    = ~pend_valid_q;
   assign clk_out      = clk_out_q;
   assign rise_pulse   = rise_q;
   assign busy         = busy_q;
   assign period_valid = pv_q;
   assign period       = period_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_jitter_clk_gen.sv
// Bench for jitter_clk_gen: randomized and directed stimulus compared each
// cycle against a waveform-level model that derives half lengths from the
// LFSR rule and periods from rising-edge timestamps.
module tb_jitter_clk_gen;
   localparam int CNT_W = 16;
   localparam int JIT_W = 8;
   localparam int SEED_V = 'hACE1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic             cfg_valid = 1'b0;
   logic [CNT_W-1:0] cfg_half = '0;
   logic [JIT_W-1:0] cfg_jit = '0;
   logic             cfg_jit_en = 1'b0;
   logic             cfg_ready, clk_out, rise_pulse, period_valid, busy;
   logic [CNT_W:0]   period;
   logic [1:0]       dbg_state_unused;

   int n_tests = 0;
   int n_fail  = 0;

   jitter_clk_gen dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_half    (cfg_half),
      .cfg_jit     (cfg_jit),
      .cfg_jit_en  (cfg_jit_en),
      .clk_out     (clk_out),
      .rise_pulse  (rise_pulse),
      .period_valid(period_valid),
      .period      (period),
      .busy        (busy),
      .dbg_state   (dbg_state_unused)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // m_ph: 0 = stopped, 1 = high half, 2 = low half (internal timeline;
   // the visible clk_out follows it one cycle later)
   int m_ph, m_left, m_lfsr;
   int a_half, a_jit, a_en, p_half, p_jit, p_en, m_pend, m_acc;
   int m_clk, e_rise, e_busy, e_pv, e_period;
   int cyc, m_last_rise, m_have_rise;

   function automatic int lfsr_step(input int s);
      if ((s & 1) != 0) return (s >> 1) ^ 'hB400;
      return s >> 1;
   endfunction

   function automatic int calc_h(input int half, input int jit, input int en, input int l);
      int r, b, h;
      r = l & ((1 << (JIT_W + 1)) - 1);
      if (r > 2 * jit) r = 2 * jit;
      b = (half == 0) ? 1 : half;
      h = (en != 0) ? b + r - jit : b;
      if (h < 1) h = 1;
      if (h > (1 << CNT_W) - 1) h = (1 << CNT_W) - 1;
      return h;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_left = 0; m_lfsr = SEED_V;
      a_half = 1; a_jit = 0; a_en = 0;
      p_half = 0; p_jit = 0; p_en = 0; m_pend = 0; m_acc = 0;
      m_clk = 0; e_rise = 0; e_busy = 0; e_pv = 0; e_period = 0;
      m_have_rise = 0; m_last_rise = 0;
   endtask

   task automatic model_edge();
      int old_ph, acc, go_high, new_clk;
      old_ph  = m_ph;
      acc     = (cfg_valid && m_pend == 0) ? 1 : 0;
      go_high = 0;
      if (old_ph == 0) begin
         if (enable) go_high = 1;
      end else begin
         m_left--;
         if (m_left == 0) begin
            if (old_ph == 1) begin
               m_left = calc_h(a_half, a_jit, a_en, m_lfsr);
               m_ph = 2;
            end else if (enable) begin
               go_high = 1;
            end else begin
               m_ph = 0;
            end
         end
      end
      if (go_high) begin
         if (m_pend != 0) begin
            a_half = p_half; a_jit = p_jit; a_en = p_en; m_pend = 0;
         end
         m_left = calc_h(a_half, a_jit, a_en, m_lfsr);
         m_ph = 1;
      end
      if (acc != 0) begin
         p_half = cfg_half; p_jit = cfg_jit; p_en = cfg_jit_en; m_pend = 1;
      end
      m_acc = acc;
      if (old_ph != 0) m_lfsr = lfsr_step(m_lfsr);
      cyc++;
      new_clk = (old_ph == 1) ? 1 : 0;
      e_rise  = (new_clk == 1 && m_clk == 0) ? 1 : 0;
      e_busy  = (old_ph != 0) ? 1 : 0;
      e_pv    = 0;
      if (old_ph == 0) m_have_rise = 0;
      if (e_rise != 0) begin
         if (m_have_rise != 0) begin
            e_pv = 1;
            e_period = cyc - m_last_rise;
         end
         m_last_rise = cyc;
         m_have_rise = 1;
      end
      m_clk = new_clk;
   endtask

   // ---------------- scoreboard / bound tracking ----------------
   int bnd_on = 0, bnd_lo = 0, bnd_hi = 0, run_len = 0, run_ok = 0;
   logic prev_clk = 1'b0;

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #2;
      check_eq("clk_out", clk_out, m_clk);
      check_eq("rise_pulse", rise_pulse, e_rise);
      check_eq("busy", busy, e_busy);
      check_eq("cfg_ready", cfg_ready, (m_pend == 0));
      check_eq("period_valid", period_valid, e_pv);
      check_eq("period", period, e_period);
      if (clk_out === prev_clk) begin
         run_len++;
      end else begin
         if (bnd_on != 0 && run_ok != 0)
            check_eq("half_in_range", (run_len >= bnd_lo && run_len <= bnd_hi), 1);
         run_ok  = 1;
         run_len = 1;
      end
      prev_clk = clk_out;
      if (bnd_on != 0 && period_valid === 1'b1)
         check_eq("period_in_range", (period >= 2 * bnd_lo && period <= 2 * bnd_hi), 1);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Driver: hold an offer until the slot takes it (bounded)
   task automatic offer(input int h, input int j, input int e);
      int got;
      cfg_half = CNT_W'(h); cfg_jit = JIT_W'(j); cfg_jit_en = e[0];
      cfg_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 400 && got == 0; i++) begin
         step();
         got = m_acc;
      end
      cfg_valid = 1'b0;
      check_eq("cfg_accept", got, 1);
   endtask

   task automatic set_bounds(input int lo, input int hi);
      bnd_lo = lo; bnd_hi = hi; run_ok = 0; bnd_on = 1;
   endtask

   initial begin
      int found;
      model_reset();
      cyc = 0;
      // Reset state
      #1;
      check_eq("rst_clk_out", clk_out, 0);
      check_eq("rst_cfg_ready", cfg_ready, 1);
      check_eq("rst_busy", busy, 0);
      run(2);

      // Defaults: divide by 2
      rst = 1'b0; enable = 1'b1;
      run(20);

      // half = 3, no jitter, offered while running
      offer(3, 0, 0);
      run(30);

      // half = 10, jit = 4
      offer(10, 4, 1);
      run(40);
      set_bounds(6, 14);
      run(400);
      bnd_on = 0;

      // half = 1, jit = 5: saturation at 1, never stalls
      offer(1, 5, 1);
      run(20);
      set_bounds(1, 6);
      run(200);
      bnd_on = 0;

      // Back-to-back offers
      offer(2, 0, 0);
      offer(5, 1, 1);
      run(40);

      // Randomized config and enable traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         cfg_valid  = ($urandom_range(0, 9) == 0);
         cfg_half   = CNT_W'($urandom_range(0, 8));
         cfg_jit    = JIT_W'($urandom_range(0, 6));
         cfg_jit_en = $urandom_range(0, 1) != 0;
         step();
      end
      cfg_valid = 1'b0;
      enable = 1'b1;
      offer(5, 0, 0);
      run(30);

      // Drop enable in the middle of HIGH
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         step();
         if (m_ph == 1 && m_left >= 3) found = 1;
      end
      check_eq("reach_mid_high", found, 1);
      enable = 1'b0;
      run(30);
      check_eq("idle_clk_out", clk_out, 0);
      check_eq("idle_busy", busy, 0);

      // Reset in the middle of LOW with a pending offer
      enable = 1'b1;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         step();
         if (m_ph == 2 && m_left >= 3) found = 1;
      end
      check_eq("reach_mid_low", found, 1);
      cfg_half = 16'd7; cfg_jit = '0; cfg_jit_en = 1'b0; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check_eq("arst_clk_out", clk_out, 0);
      check_eq("arst_rise", rise_pulse, 0);
      check_eq("arst_pv", period_valid, 0);
      check_eq("arst_period", period, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_cfg_ready", cfg_ready, 1);
      step();
      rst = 1'b0;
      run(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jitter_clk_gen.md
# jitter_clk_gen

Synthesizable, programmable clock-enable/divided-clock generator with LFSR-driven per-half-period jitter and on-line period measurement. It runs from the system clock and replaces testbench-only `#delay` clock generation. It produces a divided clock whose half-periods are a configured base length plus a bounded pseudo-random offset, and reports every measured period so jitter can be checked in simulation and on silicon.

## Interface
- `CNT_W`, 16, width of half-period length and counters.
- `JIT_W`, 8, width of the jitter bound; must satisfy `JIT_W+1 <= 16`.
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero.
- `clk`, input, 1, system clock.
- `rst`, input, 1, reset, asynchronous, active-high.
- `enable`, input, 1, run request.
- `cfg_valid`, input, 1, configuration offer.
- `cfg_ready`, output, 1, pending-config slot empty.
- `cfg_half`, input, `CNT_W`, base half-period in `clk` cycles (0 treated as 1).
- `cfg_jit`, input, `JIT_W`, maximum deviation in cycles, applied per half-period.
- `cfg_jit_en`, input, 1, jitter enable.
- `clk_out`, output, 1, generated clock (registered).
- `rise_pulse`, output, 1, one-cycle pulse in the cycle `clk_out` goes 0→1.
- `period_valid`, output, 1, one-cycle strobe qualifying `period`.
- `period`, output, `CNT_W+1`, cycles between the last two `clk_out` rising edges.
- `busy`, output, 1, FSM not in IDLE.

## Operation
- FSM states: IDLE, HIGH, LOW.
  - IDLE→HIGH when `enable`=1.
  - HIGH→LOW when the down-counter reaches 0.
  - LOW→HIGH when the counter reaches 0 and `enable`=1.
  - LOW→IDLE when the counter reaches 0 and `enable`=0.
- Disabling mid-period always completes the current period. `clk_out` is 0 in IDLE.
- Config handshake:
  - Transfer occurs when `cfg_valid && cfg_ready`. Data is captured into a single pending register and `cfg_ready` drops.
  - Pending config is promoted to active only at a period boundary: on entry to HIGH, from IDLE or LOW. `cfg_ready` returns to 1 in that same cycle.
  - A new offer arriving in the promotion cycle is not accepted until the next cycle.
- Active config reset values: half=1, jit=0, jit_en=0, which gives divide-by-2.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Reset to `SEED`; advances every cycle the FSM is not IDLE.
- Half-length computation, evaluated on every entry to HIGH or LOW:
  - r = `lfsr[JIT_W:0]`, clamped to 2·jit.
  - off = r − jit (signed).
  - h = half + off when jit_en=1, else h = half.
  - h saturates to the range [1, 2^CNT_W−1].
  - The counter loads h−1, so the state lasts exactly h cycles.
- Measurement:
  - A free-running counter clears on each rising edge and otherwise increments, saturating at all-ones.
  - At each rising edge, `period` = counter+1 and `period_valid`=1.
  - No strobe on the first rising edge after leaving IDLE; the counter is invalidated in IDLE.

## Timing
- Async reset: `clk_out`, `rise_pulse`, `period_valid`, `period`, `busy` = 0; `cfg_ready` = 1; FSM in IDLE; LFSR = `SEED`. Reset mid-period aborts immediately, and any pending config is discarded.
- `enable` sampled high in IDLE at edge t → `clk_out`=1, `busy`=1, `rise_pulse`=1 after edge t+1.
- With no jitter, `clk_out` high for exactly half cycles and low for half cycles, so period = 2·half.
- `rise_pulse` and `period_valid` coincide with the cycle `clk_out` becomes 1.
- Config accepted at cycle c takes effect on the next HIGH entry; the earliest effect is the following period.

## Structure
- Shared package `jitter_clk_pkg` contains:
  - state enum (IDLE/HIGH/LOW)
  - LFSR mask 16'hB400
  - default `SEED`
  - reset values of the active config
- Sub-module `lfsr16`: enable, seed parameter, 16-bit state output.
- Top holds the FSM, config registers, half-length arithmetic and the measurement counter.

## Test plan
- Reset, `enable`=1 with defaults → `clk_out` toggles every cycle; `period`=2 from the second rising edge; no strobe on the first edge.
- Config half=3, jit_en=0 while running → current period unchanged; subsequent periods have 3 high + 3 low and `period`=6.
- half=10, jit=4, jit_en=1, seed 16'hACE1 → every half-period within [6,14] and every `period` within [12,28]; sequence matches the reference model LFSR bit-exact.
- half=1, jit=5, jit_en=1 → no half-period shorter than 1 cycle (saturation); `clk_out` never stalls.
- Two back-to-back offers → second offer sees `cfg_ready`=0 until the boundary, then is accepted and applied one period later.
- Drop `enable` mid-HIGH → period completes, IDLE with `clk_out`=0; assert `rst` mid-LOW → all outputs 0 immediately, `cfg_ready`=1.
